// File: rtl/arith_sched.sv
`default_nettype none
// ============================================================================
//  Module   : arith_sched
//  Brief    : Two-requester round-robin scheduler sharing one registered
//             add/multiply unit. Sequence IDLE -> EXEC -> RESP, one
//             operation in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
module arith_sched #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic             r0_op,
    input  logic [W-1:0]     r0_a,
    input  logic [W-1:0]     r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic             r1_op,
    input  logic [W-1:0]     r1_a,
    input  logic [W-1:0]     r1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [2*W-1:0]   rsp_data,
    output logic             busy,
    output logic [7:0]       op_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]     r_state;
    logic [1:0]     w_next_state;
    // Low while reset is asserted and until the first clock edge after
    // release, so no grant can be offered before that edge.
    logic           r_run;
    logic           r_ptr;
    logic           r_op;
    logic           r_id;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_result;
    logic [7:0]     r_op_cnt;

    logic           w_grant0;
    logic           w_grant1;
    logic           w_grant_any;
    logic [2*W-1:0] w_sum;
    logic [2*W-1:0] w_product;

    // Both operands are zero-extended to 2W so the sum carries its extra
    // bit and the product keeps its full width.
    assign w_sum       = {{W{1'b0}}, r_a} + {{W{1'b0}}, r_b};
    assign w_product   = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
    assign w_grant_any = w_grant0 | w_grant1;

    // Next-state and arbitration: grant only in IDLE; the pointer breaks
    // ties, a lone requester wins regardless of the pointer.
    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_run) begin
                    w_grant0 = r0_valid && (!r1_valid || !r_ptr);
                    w_grant1 = r1_valid && (!r0_valid ||  r_ptr);
                end
                if (w_grant0 || w_grant1) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, captured operation, result, pointer and grant counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_run    <= 1'b0;
            r_ptr    <= 1'b0;
            r_op     <= 1'b0;
            r_id     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_op_cnt <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
            if (w_grant_any) begin
                r_op     <= w_grant1 ? r1_op : r0_op;
                r_a      <= w_grant1 ? r1_a  : r0_a;
                r_b      <= w_grant1 ? r1_b  : r0_b;
                r_id     <= w_grant1;
                r_op_cnt <= r_op_cnt + 8'd1;
            end
            if (r_state == S_EXEC) begin
                r_result <= r_op ? w_product : w_sum;
            end
            if ((r_state == S_RESP) && rsp_ready) begin
                r_ptr <= ~r_id;
            end
        end
    end

    assign r0_ready  = w_grant0;
    assign r1_ready  = w_grant1;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_id;
    assign rsp_data  = r_result;
    assign busy      = (r_state != S_IDLE);
    assign op_cnt    = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_arith_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arith_sched
//  Brief    : Self-checking bench for arith_sched: directed vector table,
//             reset-in-flight sequence, randomized transactions against a
//             transaction-level reference model, op_cnt wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arith_sched;

    localparam int C_W = 4;

    logic           clk;
    logic           rst;
    logic           r0_valid, r0_ready, r0_op;
    logic [C_W-1:0] r0_a, r0_b;
    logic           r1_valid, r1_ready, r1_op;
    logic [C_W-1:0] r1_a, r1_b;
    logic           rsp_valid, rsp_ready, rsp_id;
    logic [2*C_W-1:0] rsp_data;
    logic           busy;
    logic [7:0]     op_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state: whose turn it is on a tie, grants since reset.
    logic m_ptr = 1'b0;
    int   m_cnt = 0;

    typedef struct {
        logic       v0;
        logic       op0;
        logic [3:0] a0;
        logic [3:0] b0;
        logic       v1;
        logic       op1;
        logic [3:0] a1;
        logic [3:0] b1;
        int         hold;
        logic       exp_id;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    arith_sched #(.W(C_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_op     (r0_op),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_op     (r1_op),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction, starting in an IDLE cycle. Valids stay up
    // until the response is accepted so the loser keeps requesting.
    task automatic do_txn(input logic v0, input logic op0, input logic [3:0] a0, input logic [3:0] b0,
                          input logic v1, input logic op1, input logic [3:0] a1, input logic [3:0] b1,
                          input int hold, input logic exp_id, input logic [7:0] exp_data);
        r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
        rsp_ready = 1'b0;
        #1;
        check("grant", {r1_ready, r0_ready}, exp_id ? 2'b10 : 2'b01);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_busy", busy, 0);
        step();
        m_cnt = (m_cnt + 1) % 256;
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_ready", {r1_ready, r0_ready}, 0);
        check("op_cnt", op_cnt, m_cnt);
        step();
        for (int h = 0; h < hold; h++) begin
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_id", rsp_id, exp_id);
            check("hold_rsp_data", rsp_data, exp_data);
            check("hold_ready", {r1_ready, r0_ready}, 0);
            step();
        end
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_data", rsp_data, exp_data);
        check("resp_ready", {r1_ready, r0_ready}, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        m_ptr = ~exp_id;
        check("back_idle_rsp_valid", rsp_valid, 0);
        check("back_idle_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b0;
        r0_valid = 0; r0_op = 0; r0_a = 0; r0_b = 0;
        r1_valid = 0; r1_op = 0; r1_a = 0; r1_b = 0;
        rsp_ready = 0;

        // Hand-derived vectors; pointer starts at requester 0 after reset.
        vecs[0]  = '{1, 0, 4'd15, 4'd15, 0, 0, 4'd0,  4'd0,  0, 0, 8'h1E};
        vecs[1]  = '{1, 0, 4'd1,  4'd1,  1, 1, 4'd15, 4'd15, 5, 1, 8'hE1};
        vecs[2]  = '{1, 0, 4'd3,  4'd2,  1, 1, 4'd3,  4'd2,  0, 0, 8'h05};
        vecs[3]  = '{1, 0, 4'd3,  4'd2,  1, 1, 4'd3,  4'd2,  0, 1, 8'h06};
        vecs[4]  = '{1, 0, 4'd3,  4'd2,  1, 1, 4'd3,  4'd2,  0, 0, 8'h05};
        vecs[5]  = '{1, 0, 4'd3,  4'd2,  1, 1, 4'd3,  4'd2,  0, 1, 8'h06};
        vecs[6]  = '{0, 0, 4'd0,  4'd0,  1, 0, 4'd0,  4'd0,  0, 1, 8'h00};
        vecs[7]  = '{1, 1, 4'd0,  4'd9,  0, 0, 4'd0,  4'd0,  0, 0, 8'h00};
        vecs[8]  = '{1, 1, 4'd7,  4'd9,  0, 0, 4'd0,  4'd0,  0, 0, 8'h3F};
        vecs[9]  = '{0, 0, 4'd0,  4'd0,  1, 1, 4'd15, 4'd0,  1, 1, 8'h00};
        vecs[10] = '{1, 0, 4'd15, 4'd1,  1, 1, 4'd15, 4'd14, 0, 0, 8'h10};
        vecs[11] = '{1, 0, 4'd15, 4'd1,  1, 1, 4'd15, 4'd14, 2, 1, 8'hD2};

        // Reset state, with a request pending that must not be granted.
        r0_valid = 1'b1;
        #12;
        check("rst_ready", {r1_ready, r0_ready}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy", busy, 0);
        check("rst_op_cnt", op_cnt, 0);
        r0_valid = 1'b0;
        step();
        rst = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
                   vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1,
                   vecs[i].hold, vecs[i].exp_id, vecs[i].exp_data);
        end

        // No valid in IDLE: nothing happens, nothing is remembered.
        step();
        check("novalid_busy", busy, 0);
        check("novalid_ready", {r1_ready, r0_ready}, 0);

        // Reset during EXEC of r0 7*9: everything clears immediately.
        r0_valid = 1'b1; r0_op = 1'b1; r0_a = 4'd7; r0_b = 4'd9;
        #1;
        check("inflight_grant", {r1_ready, r0_ready}, 2'b01);
        step();
        check("inflight_exec_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("midrst_ready", {r1_ready, r0_ready}, 0);
        check("midrst_rsp_valid", rsp_valid, 0);
        check("midrst_rsp_id", rsp_id, 0);
        check("midrst_rsp_data", rsp_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_op_cnt", op_cnt, 0);
        r0_valid = 1'b0;
        step();
        rst = 1'b1;
        m_ptr = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("discard_rsp_valid", rsp_valid, 0);
            check("discard_busy", busy, 0);
        end

        // Pointer back at requester 0: a tie goes to r0.
        do_txn(1, 0, 4'd1, 4'd2, 1, 0, 4'd3, 4'd4, 0, 0, 8'h03);

        // Randomized transactions against the model; 255 more grants make
        // 256 since reset, so op_cnt must wrap to zero.
        for (int i = 0; i < 255; i++) begin
            logic [1:0] v;
            logic       op0, op1, eid;
            logic [3:0] a0, b0, a1, b1;
            int         res;
            v   = 2'($urandom_range(1, 3));
            op0 = 1'($urandom); op1 = 1'($urandom);
            a0  = 4'($urandom); b0 = 4'($urandom);
            a1  = 4'($urandom); b1 = 4'($urandom);
            eid = (v[0] && v[1]) ? m_ptr : v[1];
            if (eid) res = op1 ? int'(a1) * int'(b1) : int'(a1) + int'(b1);
            else     res = op0 ? int'(a0) * int'(b0) : int'(a0) + int'(b0);
            do_txn(v[0], op0, a0, b0, v[1], op1, a1, b1,
                   int'($urandom_range(0, 2)), eid, 8'(res));
        end
        check("op_cnt_wrap", op_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
